// File: rtl/ysyx_23060184_defs_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060184_defs
// Shared definitions for the ysyx_23060184 core.
//   ifu_state_e  : instruction fetch unit FSM states (3-bit encoding)
//   RESP_OKAY    : AXI4-Lite read response value meaning success
//   IFU_RESET_PC : default architectural PC after reset
// ---------------------------------------------------------------------------
package ysyx_23060184_defs;

    typedef enum logic [2:0] {
        IFU_IDLE     = 3'd0,
        IFU_AR       = 3'd1,
        IFU_R        = 3'd2,
        IFU_HOLD     = 3'd3,
        IFU_WAIT_NPC = 3'd4,
        IFU_HALT     = 3'd5
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060184_Reg.sv
// ---------------------------------------------------------------------------
// ysyx_23060184_Reg
// Generic register with write enable and asynchronous active-low reset to a
// parameterised value.
//   i_clk    : clock, captures on rising edge
//   i_rst_n  : asynchronous active-low reset, loads RESET_VAL
//   i_wen    : write enable
//   i_din    : data to capture when i_wen is high
//   o_dout   : registered value
// ---------------------------------------------------------------------------
module ysyx_23060184_Reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wen,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= RESET_VAL;
        end else if (i_wen) begin
            r_q <= i_din;
        end
    end

    assign o_dout = r_q;

endmodule

// File: rtl/ysyx_23060184_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_23060184_ifu
// Instruction fetch unit: holds the PC, fetches one instruction at a time
// over an AXI4-Lite-style read channel and hands it to decode with a
// valid/ready handshake. The next fetch address comes from the next-PC stage.
//   clk, resetn        : clock / asynchronous active-low reset
//   npc, npc_valid     : next PC from the next-PC stage
//   imem_ar*           : read address channel (address = pc)
//   imem_r*            : read data channel
//   pc, inst           : PC and instruction presented to decode
//   inst_valid/ready   : handshake with decode
//   fetch_err          : sticky fault flag, unit is halted while set
// All outputs come from registers or from the state register alone.
// ---------------------------------------------------------------------------
module ysyx_23060184_ifu
    import ysyx_23060184_defs::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = IFU_RESET_PC
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] npc,
    input  logic                  npc_valid,
    output logic                  imem_arvalid,
    output logic [DATA_WIDTH-1:0] imem_araddr,
    input  logic                  imem_arready,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic [1:0]            imem_rresp,
    output logic                  imem_rready,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] inst,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic                  fetch_err
);

    ifu_state_e            r_state;
    ifu_state_e            w_state_next;
    logic [DATA_WIDTH-1:0] r_inst;
    logic                  r_fetch_err;
    logic [DATA_WIDTH-1:0] w_pc;
    logic                  w_pc_wen;
    logic                  w_inst_wen;
    logic                  w_err_set;

    ysyx_23060184_Reg #(
        .WIDTH     (DATA_WIDTH),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .i_clk   (clk),
        .i_rst_n (resetn),
        .i_wen   (w_pc_wen),
        .i_din   (npc),
        .o_dout  (w_pc)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IFU_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A misaligned npc or an error response halts fetch permanently; pc is
    // only written on an aligned npc so it still names the last good fetch.
    always_comb begin
        w_state_next = r_state;
        w_pc_wen     = 1'b0;
        w_inst_wen   = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            IFU_IDLE: begin
                w_state_next = IFU_AR;
            end
            IFU_AR: begin
                if (imem_arready) begin
                    w_state_next = IFU_R;
                end
            end
            IFU_R: begin
                if (imem_rvalid) begin
                    if (imem_rresp == RESP_OKAY) begin
                        w_inst_wen   = 1'b1;
                        w_state_next = IFU_HOLD;
                    end else begin
                        w_err_set    = 1'b1;
                        w_state_next = IFU_HALT;
                    end
                end
            end
            IFU_HOLD: begin
                if (inst_ready) begin
                    w_state_next = IFU_WAIT_NPC;
                end
            end
            IFU_WAIT_NPC: begin
                if (npc_valid) begin
                    if (npc[1:0] == 2'b00) begin
                        w_pc_wen     = 1'b1;
                        w_state_next = IFU_AR;
                    end else begin
                        w_err_set    = 1'b1;
                        w_state_next = IFU_HALT;
                    end
                end
            end
            IFU_HALT: begin
                w_state_next = IFU_HALT;
            end
            default: begin
                w_state_next = IFU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inst      <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            if (w_inst_wen) begin
                r_inst <= imem_rdata;
            end
            if (w_err_set) begin
                r_fetch_err <= 1'b1;
            end
        end
    end

    // Handshake outputs are pure state decodes, so arvalid and rready can
    // never overlap and nothing combinational leaks from inputs.
    assign imem_arvalid = (r_state == IFU_AR);
    assign imem_rready  = (r_state == IFU_R);
    assign inst_valid   = (r_state == IFU_HOLD);
    assign imem_araddr  = w_pc;
    assign pc           = w_pc;
    assign inst         = r_inst;
    assign fetch_err    = r_fetch_err;

endmodule

// File: tb/tb_ysyx_23060184_ifu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060184_ifu
// Self-checking bench for the instruction fetch unit. The bench plays both
// the instruction memory and decode, driving inputs on the falling edge and
// sampling outputs on the falling edge.
// ---------------------------------------------------------------------------
module tb_ysyx_23060184_ifu;

    logic        clk;
    logic        resetn;
    logic [31:0] npc;
    logic        npc_valid;
    logic        imem_arvalid;
    logic [31:0] imem_araddr;
    logic        imem_arready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [1:0]  imem_rresp;
    logic        imem_rready;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;
    int arHandshakes = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        int          arWait;
        int          rWait;
        int          readyWait;
        logic [31:0] npcVal;
        logic        expErr;
    } vec_t;

    vec_t vecs[3];

    ysyx_23060184_ifu dut (
        .clk          (clk),
        .resetn       (resetn),
        .npc          (npc),
        .npc_valid    (npc_valid),
        .imem_arvalid (imem_arvalid),
        .imem_araddr  (imem_araddr),
        .imem_arready (imem_arready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .imem_rresp   (imem_rresp),
        .imem_rready  (imem_rready),
        .pc           (pc),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .fetch_err    (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts accepted read-address beats so duplicate requests show up.
    always @(posedge clk) begin
        if (resetn && imem_arvalid && imem_arready) begin
            arHandshakes <= arHandshakes + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_pc"},         pc,           32'h8000_0000);
        checkOutput({tag, "_inst"},       inst,         32'h0);
        checkOutput({tag, "_arvalid"},    {31'b0, imem_arvalid}, 32'h0);
        checkOutput({tag, "_rready"},     {31'b0, imem_rready},  32'h0);
        checkOutput({tag, "_inst_valid"}, {31'b0, inst_valid},   32'h0);
        checkOutput({tag, "_fetch_err"},  {31'b0, fetch_err},    32'h0);
    endtask

    task automatic applyStimulus(input int cycles);
        resetn       = 1'b0;
        npc          = 32'h0;
        npc_valid    = 1'b0;
        imem_arready = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        imem_rresp   = 2'b00;
        inst_ready   = 1'b0;
        repeat (cycles) @(negedge clk);
        checkResetOutputs("reset");
        resetn = 1'b1;
        #1;
        checkOutput("idle_no_arvalid", {31'b0, imem_arvalid}, 32'h0);
    endtask

    // Waits (bounded) for arvalid; the caller is always one edge away from AR.
    task automatic waitArvalid(input int expCycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            npc_valid = 1'b0;
            n++;
        end while (!imem_arvalid && n < 20);
        checkOutput("arvalid_latency", n, expCycles);
    endtask

    // Runs one read: address phase with arWait stalls, data phase with rWait
    // stalls, then returns at the falling edge after the data beat.
    task automatic doFetch(input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [1:0] resp, input int arWait, input int rWait);
        int hs0;
        hs0 = arHandshakes;
        waitArvalid(1);
        checkOutput("araddr", imem_araddr, addr);
        for (int i = 0; i < arWait; i++) begin
            @(negedge clk);
            checkOutput("ar_hold_valid", {31'b0, imem_arvalid}, 32'h1);
            checkOutput("ar_hold_addr", imem_araddr, addr);
        end
        imem_arready = 1'b1;
        @(negedge clk);
        imem_arready = 1'b0;
        checkOutput("r_rready", {31'b0, imem_rready}, 32'h1);
        checkOutput("r_no_arvalid", {31'b0, imem_arvalid}, 32'h0);
        checkOutput("ar_handshake_count", arHandshakes - hs0, 32'd1);
        for (int i = 0; i < rWait; i++) begin
            @(negedge clk);
            checkOutput("r_wait_rready", {31'b0, imem_rready}, 32'h1);
            checkOutput("r_wait_no_valid", {31'b0, inst_valid}, 32'h0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = rdata;
        imem_rresp  = resp;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rresp  = 2'b00;
    endtask

    // Decode side: stall readyWait cycles (with a stray misaligned npc_valid
    // that must be ignored), accept, then present the next PC.
    task automatic acceptAndNpc(input int readyWait, input logic [31:0] expInst,
                                input logic [31:0] expPc, input logic [31:0] npcVal);
        checkOutput("hold_valid", {31'b0, inst_valid}, 32'h1);
        checkOutput("hold_inst", inst, expInst);
        checkOutput("hold_pc", pc, expPc);
        for (int i = 0; i < readyWait; i++) begin
            npc       = 32'hDEAD_BEE2;
            npc_valid = 1'b1;
            @(negedge clk);
            checkOutput("bp_valid", {31'b0, inst_valid}, 32'h1);
            checkOutput("bp_inst", inst, expInst);
            checkOutput("bp_pc", pc, expPc);
            checkOutput("bp_no_arvalid", {31'b0, imem_arvalid}, 32'h0);
            checkOutput("bp_no_err", {31'b0, fetch_err}, 32'h0);
        end
        npc_valid  = 1'b0;
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        checkOutput("wait_npc_valid_low", {31'b0, inst_valid}, 32'h0);
        @(negedge clk);
        checkOutput("wait_npc_no_arvalid", {31'b0, imem_arvalid}, 32'h0);
        npc       = npcVal;
        npc_valid = 1'b1;
    endtask

    initial begin
        vecs[0] = '{addr: 32'h8000_0000, rdata: 32'h0000_0013, arWait: 0, rWait: 0,
                    readyWait: 0, npcVal: 32'h8000_0004, expErr: 1'b0};
        vecs[1] = '{addr: 32'h8000_0004, rdata: 32'h0050_0093, arWait: 3, rWait: 2,
                    readyWait: 5, npcVal: 32'h8000_0100, expErr: 1'b0};
        vecs[2] = '{addr: 32'h8000_0100, rdata: 32'hFFF0_0113, arWait: 1, rWait: 0,
                    readyWait: 1, npcVal: 32'h8000_0102, expErr: 1'b1};

        applyStimulus(3);
        for (int v = 0; v < 3; v++) begin
            doFetch(vecs[v].addr, vecs[v].rdata, 2'b00, vecs[v].arWait, vecs[v].rWait);
            acceptAndNpc(vecs[v].readyWait, vecs[v].rdata, vecs[v].addr, vecs[v].npcVal);
            if (vecs[v].expErr) begin
                @(negedge clk);
                npc_valid = 1'b0;
                checkOutput("npc_misalign_err", {31'b0, fetch_err}, 32'h1);
                checkOutput("npc_misalign_pc", pc, vecs[v].addr);
                repeat (4) begin
                    @(negedge clk);
                    checkOutput("halt_no_arvalid", {31'b0, imem_arvalid}, 32'h0);
                end
            end
        end

        // Error response: halt without ever presenting the instruction.
        applyStimulus(2);
        doFetch(32'h8000_0000, 32'h1234_5678, 2'b10, 0, 0);
        checkOutput("rresp_err", {31'b0, fetch_err}, 32'h1);
        checkOutput("rresp_no_valid", {31'b0, inst_valid}, 32'h0);
        npc_valid = 1'b1;
        npc       = 32'h8000_0200;
        repeat (5) begin
            @(negedge clk);
            checkOutput("rresp_halt_err", {31'b0, fetch_err}, 32'h1);
            checkOutput("rresp_halt_valid", {31'b0, inst_valid}, 32'h0);
            checkOutput("rresp_halt_ar", {31'b0, imem_arvalid}, 32'h0);
            checkOutput("rresp_halt_r", {31'b0, imem_rready}, 32'h0);
        end
        npc_valid = 1'b0;

        // Reset pulse while waiting in R: outputs drop at once, fetch restarts.
        applyStimulus(2);
        doFetch(32'h8000_0000, 32'h0000_0013, 2'b00, 0, 0);
        acceptAndNpc(0, 32'h0000_0013, 32'h8000_0000, 32'h8000_0040);
        waitArvalid(1);
        checkOutput("pre_abort_addr", imem_araddr, 32'h8000_0040);
        imem_arready = 1'b1;
        @(negedge clk);
        imem_arready = 1'b0;
        checkOutput("pre_abort_in_r", {31'b0, imem_rready}, 32'h1);
        resetn = 1'b0;
        #1;
        checkResetOutputs("abort");
        @(negedge clk);
        applyStimulus(1);
        doFetch(32'h8000_0000, 32'h0010_0073, 2'b00, 0, 0);
        acceptAndNpc(0, 32'h0010_0073, 32'h8000_0000, 32'h8000_0004);
        waitArvalid(1);
        checkOutput("restart_next_addr", imem_araddr, 32'h8000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
